// File: rtl/castle_gfx_pkg.sv
// rtl/castle_gfx_pkg.sv - shared widths, colour/mode/state types and screen size for the tile painter
package castle_gfx_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int CNT_W    = 5;
    localparam int COLOUR_W = 3;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        MODE_FILL    = 2'b00,
        MODE_INSET   = 2'b01,
        MODE_OUTLINE = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PAINT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/tile_pixel_classify.sv
// rtl/tile_pixel_classify.sv - per-offset plot enable and fg/bg select for FILL, INSET and OUTLINE
module tile_pixel_classify #(
    parameter int TILE     = 25,
    parameter int INSET    = 5,
    parameter int BORDER_W = 1
) (
    input  logic [4:0] dx,
    input  logic [4:0] dy,
    input  logic [1:0] mode,
    output logic       plot_en,
    output logic       use_fg
);
    import castle_gfx_pkg::*;

    localparam logic [CNT_W-1:0] CORE_LO = CNT_W'(INSET);
    localparam logic [CNT_W-1:0] CORE_HI = CNT_W'(TILE - 1 - INSET);
    localparam logic [CNT_W-1:0] RING_LO = CNT_W'(BORDER_W);
    localparam logic [CNT_W-1:0] RING_HI = CNT_W'(TILE - BORDER_W);

    logic in_core;
    logic on_ring;

    assign in_core = (dx >= CORE_LO) && (dx <= CORE_HI) &&
                     (dy >= CORE_LO) && (dy <= CORE_HI);
    assign on_ring = (dx < RING_LO) || (dx >= RING_HI) ||
                     (dy < RING_LO) || (dy >= RING_HI);

    // Reserved mode falls through to the FILL default.
    always_comb begin
        plot_en = 1'b1;
        use_fg  = 1'b0;
        case (mode_t'(mode))
            MODE_INSET: use_fg = in_core;
            MODE_OUTLINE: begin
                plot_en = on_ring;
                use_fg  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tile_painter.sv
// rtl/tile_painter.sv - scans one TILE x TILE tile into registered VGA pixel writes; TILE_PAINTER_CLIP_EN enables screen clipping
module tile_painter #(
    parameter int TILE     = 25,
    parameter int INSET    = 5,
    parameter int BORDER_W = 1,
    parameter int SCREEN_W = castle_gfx_pkg::DEF_SCREEN_W,
    parameter int SCREEN_H = castle_gfx_pkg::DEF_SCREEN_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw,
    input  logic       abort,
    input  logic [1:0] mode,
    input  logic [7:0] start_x,
    input  logic [6:0] start_y,
    input  logic [2:0] bg_colour,
    input  logic [2:0] fg_colour,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    import castle_gfx_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TILE - 1);

    state_t           state, state_next;
    logic             accept;
    logic             last_px;
    logic [CNT_W-1:0] dx, dy;
    logic [1:0]       mode_l;
    logic [X_W-1:0]   sx_l;
    logic [Y_W-1:0]   sy_l;
    colour_t          bg_l, fg_l;
    logic             plot_en, use_fg, on_screen;
    logic [X_W-1:0]   px_x;
    logic [Y_W-1:0]   px_y;

    tile_pixel_classify #(
        .TILE     (TILE),
        .INSET    (INSET),
        .BORDER_W (BORDER_W)
    ) u_classify (
        .dx      (dx),
        .dy      (dy),
        .mode    (mode_l),
        .plot_en (plot_en),
        .use_fg  (use_fg)
    );

`ifdef TILE_PAINTER_CLIP_EN
    // Compare the untruncated sums so tiles hanging off the right/bottom edge do not wrap back on screen.
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    assign sum_x     = {1'b0, sx_l} + {{(X_W-CNT_W+1){1'b0}}, dx};
    assign sum_y     = {1'b0, sy_l} + {{(Y_W-CNT_W+1){1'b0}}, dy};
    assign on_screen = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
    assign px_x      = sum_x[X_W-1:0];
    assign px_y      = sum_y[Y_W-1:0];
`else
    assign px_x      = sx_l + {{(X_W-CNT_W){1'b0}}, dx};
    assign px_y      = sy_l + {{(Y_W-CNT_W){1'b0}}, dy};
    assign on_screen = 1'b1;
`endif

    assign last_px = (dx == LAST) && (dy == LAST);
    assign busy    = (state == S_PAINT);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (draw && !abort) begin
                    state_next = S_PAINT;
                    accept     = 1'b1;
                end
            end
            S_PAINT: begin
                if (abort)        state_next = S_IDLE;
                else if (last_px) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx         <= '0;
            dy         <= '0;
            mode_l     <= 2'b00;
            sx_l       <= '0;
            sy_l       <= '0;
            bg_l       <= '0;
            fg_l       <= '0;
            x_pos      <= '0;
            y_pos      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (accept) begin
                mode_l <= mode;
                sx_l   <= start_x;
                sy_l   <= start_y;
                bg_l   <= bg_colour;
                fg_l   <= fg_colour;
            end
            if (state == S_PAINT && !abort) begin
                x_pos      <= px_x;
                y_pos      <= px_y;
                colour_out <= use_fg ? fg_l : bg_l;
                plot       <= plot_en && on_screen;
                if (dx == LAST) begin
                    dx <= '0;
                    dy <= dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end else begin
                plot <= 1'b0;
                dx   <= '0;
                dy   <= '0;
            end
        end
    end

endmodule
